// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch PC generator: npc source encoding, 2-bit counter
// states, and the BTB entry layout.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_PLUS4    = 3'd0,
        NPC_PRED     = 3'd1,
        NPC_HOLD     = 3'd2,
        NPC_REDIRECT = 3'd3,
        NPC_MRET     = 3'd4,
        NPC_TRAP     = 3'd5
    } npc_src_e;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    // Fields sized for a 32-bit core; the tag holds pc >> (index bits + 2).
    localparam int BTB_FIELD_W = 32;

    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
        logic [1:0]             ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken) return (c == STRONG_T)  ? STRONG_T  : c + 2'd1;
        else       return (c == STRONG_NT) ? STRONG_NT : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational; training from EX is written at the clock edge.
module btb_dm
    import pc_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] lk_pc_i,
    output logic            lk_taken_o,
    output logic [XLEN-1:0] lk_target_o,
    input  logic            up_en_i,
    input  logic [XLEN-1:0] up_pc_i,
    input  logic            up_taken_i,
    input  logic [XLEN-1:0] up_target_i
);
    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t             entries_q [ENTRIES];
    btb_entry_t             lk_e;
    btb_entry_t             up_e;
    logic [IDX_W-1:0]       lk_idx;
    logic [IDX_W-1:0]       up_idx;
    logic [BTB_FIELD_W-1:0] lk_tag;
    logic [BTB_FIELD_W-1:0] up_tag;
    logic                   up_hit;

    assign lk_idx = lk_pc_i[IDX_W+1:2];
    assign up_idx = up_pc_i[IDX_W+1:2];
    assign lk_tag = BTB_FIELD_W'(lk_pc_i >> (IDX_W + 2));
    assign up_tag = BTB_FIELD_W'(up_pc_i >> (IDX_W + 2));

    assign lk_e        = entries_q[lk_idx];
    assign up_e        = entries_q[up_idx];
    assign up_hit      = up_e.valid && (up_e.tag == up_tag);
    assign lk_taken_o  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
    assign lk_target_o = XLEN'(lk_e.target);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
            end
        end else if (up_en_i) begin
            if (up_hit) begin
                entries_q[up_idx].ctr <= ctr_step(up_e.ctr, up_taken_i);
                if (up_taken_i) entries_q[up_idx].target <= BTB_FIELD_W'(up_target_i);
            end else if (up_taken_i) begin
                // Not-taken misses never allocate, so cold branches cost no entry.
                entries_q[up_idx] <= '{valid: 1'b1, tag: up_tag,
                                       target: BTB_FIELD_W'(up_target_i), ctr: WEAK_T};
            end
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Registered fetch-PC generator with fixed-priority redirect arbitration.
// Define PC_GEN_BTB_EN to include the branch target buffer predictor.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC    = 32'h8000_0000,
    parameter int              BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            PCWrite,
    input  logic            trap_req,
    input  logic            mret_req,
    input  logic [XLEN-1:0] sepc,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_update,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_br_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            pred_taken,
    output logic [2:0]      npc_src
);
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] npc_d;
    npc_src_e        src_d;
    logic            pred_hit;
    logic [XLEN-1:0] pred_target;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

`ifdef PC_GEN_BTB_EN
    btb_dm #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rstn        (rstn),
        .lk_pc_i     (pc_q),
        .lk_taken_o  (pred_hit),
        .lk_target_o (pred_target),
        .up_en_i     (ex_update),
        .up_pc_i     (ex_pc),
        .up_taken_i  (ex_taken),
        .up_target_i (ex_br_target)
    );
`else
    logic unused_btb_inputs;
    assign unused_btb_inputs = ^{ex_update, ex_pc, ex_taken, ex_br_target};
    assign pred_hit    = 1'b0;
    assign pred_target = '0;
`endif

    // Flush sources sit above the stall so a redirect is never lost to PCWrite=0.
    always_comb begin
        npc_d = pc_q + XLEN'(4);
        src_d = NPC_PLUS4;
        if (trap_req) begin
            npc_d = align(TRAP_VEC);
            src_d = NPC_TRAP;
        end else if (mret_req) begin
            npc_d = align(sepc);
            src_d = NPC_MRET;
        end else if (ex_redirect) begin
            npc_d = align(ex_target);
            src_d = NPC_REDIRECT;
        end else if (!PCWrite) begin
            npc_d = pc_q;
            src_d = NPC_HOLD;
        end else if (pred_hit) begin
            npc_d = align(pred_target);
            src_d = NPC_PRED;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc_q <= RESET_PC;
        else       pc_q <= npc_d;
    end

    assign pc         = pc_q;
    assign npc        = npc_d;
    assign npc_src    = src_d;
    assign pred_taken = (src_d == NPC_PRED);

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: the driver queues hand-computed results per
// cycle and a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_gen_unit;
    import pc_gen_pkg::*;

`ifdef PC_GEN_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        PCWrite = 1'b1;
    logic        trap_req = 1'b0;
    logic        mret_req = 1'b0;
    logic [31:0] sepc = '0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_update = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_br_target = '0;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pred_taken;
    logic [2:0]  npc_src;

    pc_gen_unit dut (
        .clk          (clk),
        .rstn         (rstn),
        .PCWrite      (PCWrite),
        .trap_req     (trap_req),
        .mret_req     (mret_req),
        .sepc         (sepc),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .ex_update    (ex_update),
        .ex_pc        (ex_pc),
        .ex_taken     (ex_taken),
        .ex_br_target (ex_br_target),
        .pc           (pc),
        .npc          (npc),
        .pred_taken   (pred_taken),
        .npc_src      (npc_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [2:0]  src;
        logic        pred;
    } exp_t;

    exp_t exp_q[$];
    logic chk = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard_empty: DUT output with no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (pc !== e.pc) begin
                    n_err++;
                    $display("FAIL %s.pc: got %h expected %h", e.name, pc, e.pc);
                end
                n_cmp++;
                if (npc !== e.npc) begin
                    n_err++;
                    $display("FAIL %s.npc: got %h expected %h", e.name, npc, e.npc);
                end
                n_cmp++;
                if (npc_src !== e.src) begin
                    n_err++;
                    $display("FAIL %s.npc_src: got %0d expected %0d", e.name, npc_src, e.src);
                end
                n_cmp++;
                if (pred_taken !== e.pred) begin
                    n_err++;
                    $display("FAIL %s.pred_taken: got %b expected %b", e.name, pred_taken, e.pred);
                end
            end
        end
    end

    task automatic drv(input logic trap, input logic mret, input logic [31:0] sp,
                       input logic redir, input logic [31:0] tgt, input logic pcw,
                       input logic upd, input logic [31:0] upc, input logic utk,
                       input logic [31:0] utgt);
        trap_req = trap; mret_req = mret; sepc = sp;
        ex_redirect = redir; ex_target = tgt; PCWrite = pcw;
        ex_update = upd; ex_pc = upc; ex_taken = utk; ex_br_target = utgt;
    endtask

    task automatic idle();
        drv(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
    endtask

    // Queue the expectation for this cycle, then let one rising edge go by.
    task automatic tick(input string name, input logic [31:0] epc, input logic [31:0] enpc,
                        input npc_src_e esrc, input logic epred);
        exp_t e;
        e.name = name; e.pc = epc; e.npc = enpc; e.src = 3'(esrc); e.pred = epred;
        exp_q.push_back(e);
        chk = 1'b1;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        tick("reset", 32'h0, 32'h4, NPC_PLUS4, 0);
        rstn = 1'b1;

        tick("seq0", 32'h0, 32'h4, NPC_PLUS4, 0);
        tick("seq1", 32'h4, 32'h8, NPC_PLUS4, 0);
        tick("seq2", 32'h8, 32'hC, NPC_PLUS4, 0);
        PCWrite = 0;
        tick("stall", 32'hC, 32'hC, NPC_HOLD, 0);
        drv(0, 0, 32'h0, 1, 32'h103, 0, 0, 32'h0, 0, 32'h0);
        tick("redir_over_stall", 32'hC, 32'h100, NPC_REDIRECT, 0);
        drv(1, 1, 32'h40, 1, 32'h300, 1, 0, 32'h0, 0, 32'h0);
        tick("trap_prio", 32'h100, 32'h8000_0000, NPC_TRAP, 0);
        drv(0, 1, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        tick("mret_zero", 32'h8000_0000, 32'h0, NPC_MRET, 0);
        drv(0, 1, 32'h41, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        tick("mret_align", 32'h0, 32'h40, NPC_MRET, 0);
        drv(0, 1, 32'h200, 1, 32'h300, 1, 0, 32'h0, 0, 32'h0);
        tick("mret_over_redir", 32'h40, 32'h200, NPC_MRET, 0);
        drv(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, 32'h0);
        tick("redir_top", 32'h200, 32'hFFFF_FFFC, NPC_REDIRECT, 0);
        idle();
        tick("wrap", 32'hFFFF_FFFC, 32'h0, NPC_PLUS4, 0);
        tick("after_wrap", 32'h0, 32'h4, NPC_PLUS4, 0);

        // BTB: allocate 0x20 -> 0x80 (taken) while steering fetch toward 0x20.
        drv(0, 0, 32'h0, 1, 32'h1C, 1, 1, 32'h20, 1, 32'h80);
        tick("train_alloc", 32'h4, 32'h1C, NPC_REDIRECT, 0);
        idle();
        tick("pre_br", 32'h1C, 32'h20, NPC_PLUS4, 0);
        tick("predict", 32'h20, BTB ? 32'h80 : 32'h24,
             BTB ? NPC_PRED : NPC_PLUS4, BTB);
        drv(0, 0, 32'h0, 1, 32'h20, 1, 1, 32'h20, 0, 32'h0);
        tick("nt_update1", BTB ? 32'h80 : 32'h24, 32'h20, NPC_REDIRECT, 0);
        // counter now weak-NT; same-cycle taken update must not be seen by lookup
        drv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h20, 1, 32'h90);
        tick("same_cycle_upd", 32'h20, 32'h24, NPC_PLUS4, 0);
        drv(0, 0, 32'h0, 1, 32'h20, 1, 0, 32'h0, 0, 32'h0);
        tick("back_to_br", 32'h24, 32'h20, NPC_REDIRECT, 0);
        drv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h20, 0, 32'h0);
        tick("predict_new_tgt", 32'h20, BTB ? 32'h90 : 32'h24,
             BTB ? NPC_PRED : NPC_PLUS4, BTB);
        drv(0, 0, 32'h0, 1, 32'h20, 1, 1, 32'h20, 0, 32'h0);
        tick("nt_update2", BTB ? 32'h90 : 32'h24, 32'h20, NPC_REDIRECT, 0);
        idle();
        tick("no_predict", 32'h20, 32'h24, NPC_PLUS4, 0);

        // Retrain to weak-T, then fetch the aliasing address 0x40 (same index).
        drv(0, 0, 32'h0, 1, 32'h40, 1, 1, 32'h20, 1, 32'h80);
        tick("retrain1", 32'h24, 32'h40, NPC_REDIRECT, 0);
        drv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h20, 1, 32'h80);
        tick("alias_a", 32'h40, 32'h44, NPC_PLUS4, 0);
        drv(0, 0, 32'h0, 1, 32'h40, 1, 0, 32'h0, 0, 32'h0);
        tick("to_alias", 32'h44, 32'h40, NPC_REDIRECT, 0);
        idle();
        tick("alias_b", 32'h40, 32'h44, NPC_PLUS4, 0);
        drv(0, 0, 32'h0, 1, 32'h20, 1, 0, 32'h0, 0, 32'h0);
        tick("to_br", 32'h44, 32'h20, NPC_REDIRECT, 0);
        idle();
        tick("predict_again", 32'h20, BTB ? 32'h80 : 32'h24,
             BTB ? NPC_PRED : NPC_PLUS4, BTB);
        // Not-taken miss at 0x44 must not allocate.
        drv(0, 0, 32'h0, 1, 32'h44, 1, 1, 32'h44, 0, 32'h60);
        tick("nt_miss", BTB ? 32'h80 : 32'h24, 32'h44, NPC_REDIRECT, 0);
        idle();
        tick("no_alloc", 32'h44, 32'h48, NPC_PLUS4, 0);

        // Asynchronous reset in mid-cycle clears pc before any clock edge.
        #2;
        rstn = 1'b0;
        #1;
        tick("reset_mid", 32'h0, 32'h4, NPC_PLUS4, 0);
        #2;
        rstn = 1'b1;
        tick("post_reset", 32'h0, 32'h4, NPC_PLUS4, 0);

        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
